// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: FSM encoding, mode encoding, arctangent table and saturation helper.
// Pure package; no timing or flow-control behaviour of its own.
package cordic_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_ITER = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    // atan(2^-i) with pi = 2^31; rescaled per angle width by atan_scaled()
    localparam longint ATAN32 [16] = '{
        64'd536870912, 64'd316933406, 64'd167458907, 64'd85004756,
        64'd42667331,  64'd21354465,  64'd10679838,  64'd5340245,
        64'd2670163,   64'd1335087,   64'd667544,    64'd333772,
        64'd166886,    64'd83443,     64'd41722,     64'd20861
    };

    function automatic longint atan_scaled(input logic [3:0] idx, input int angle_w);
        if (angle_w >= 32) begin
            return ATAN32[idx];
        end
        return (ATAN32[idx] + (longint'(1) <<< (31 - angle_w))) >>> (32 - angle_w);
    endfunction

    function automatic longint sat_signed(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/cordic_engine_if.sv
// Start/done request bus of the CORDIC engine: operands in, saturated results out.
// ready/done are level signals; start is only honoured while ready is high.
interface cordic_engine_if #(
    parameter int WIDTH   = 12,
    parameter int ANGLE_W = 12
);
    logic                      start;
    logic                      mode;
    logic signed [WIDTH-1:0]   x_in;
    logic signed [WIDTH-1:0]   y_in;
    logic signed [ANGLE_W-1:0] z_in;
    logic                      ready;
    logic                      done;
    logic signed [WIDTH-1:0]   x_out;
    logic signed [WIDTH-1:0]   y_out;
    logic signed [ANGLE_W-1:0] z_out;

    modport master (
        output start, mode, x_in, y_in, z_in,
        input  ready, done, x_out, y_out, z_out
    );

    modport slave (
        input  start, mode, x_in, y_in, z_in,
        output ready, done, x_out, y_out, z_out
    );
endinterface

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation; d_neg selects d = -1, otherwise d = +1.
// Zero latency, no flow control.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int IW      = 14,
    parameter int ANGLE_W = 12
) (
    input  logic signed [IW-1:0]      x,
    input  logic signed [IW-1:0]      y,
    input  logic signed [ANGLE_W-1:0] z,
    input  logic        [3:0]         i,
    input  logic                      d_neg,
    output logic signed [IW-1:0]      x_next,
    output logic signed [IW-1:0]      y_next,
    output logic signed [ANGLE_W-1:0] z_next
);
    logic signed [ANGLE_W-1:0] atan_tab [16];
    logic signed [ANGLE_W-1:0] atan_i;
    logic signed [IW-1:0]      x_sh;
    logic signed [IW-1:0]      y_sh;

    for (genvar k = 0; k < 16; k++) begin : g_atan
        assign atan_tab[k] = ANGLE_W'(atan_scaled(4'(k), ANGLE_W));
    end

    assign atan_i = atan_tab[i];
    assign x_sh   = x >>> i;
    assign y_sh   = y >>> i;

    always_comb begin
        x_next = x - y_sh;
        y_next = y + x_sh;
        z_next = z - atan_i;
        if (d_neg) begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + atan_i;
        end
    end
endmodule

// File: rtl/cordic_engine.sv
// Iterative CORDIC (rotation/vectoring), done ITERS+1 cycles after accepted start; start ignored unless ready.
// Define CORDIC_QUAD_EXT_EN for a +/-pi/2 pre-rotation giving full-circle operand range.
module cordic_engine
    import cordic_pkg::*;
#(
    parameter int WIDTH   = 12,
    parameter int ANGLE_W = 12,
    parameter int ITERS   = 10
) (
    input  logic           clock,
    input  logic           reset,
    cordic_engine_if.slave bus
);
    localparam int         IW        = WIDTH + 2;
    localparam logic [3:0] LAST_ITER = 4'(ITERS - 1);

    if (ITERS < 1 || ITERS > 16) begin : g_iters_check
        $error("cordic_engine: ITERS must be within 1..16");
    end

    logic [1:0]                state;
    logic [3:0]                iter;
    logic                      mode_r;
    logic signed [IW-1:0]      x_r;
    logic signed [IW-1:0]      y_r;
    logic signed [ANGLE_W-1:0] z_r;
    logic signed [IW-1:0]      x_pre;
    logic signed [IW-1:0]      y_pre;
    logic signed [ANGLE_W-1:0] z_pre;
    logic signed [IW-1:0]      x_nx;
    logic signed [IW-1:0]      y_nx;
    logic signed [ANGLE_W-1:0] z_nx;
    logic                      d_neg;
    logic                      ready;
    logic                      done_r;
    logic signed [WIDTH-1:0]   x_res;
    logic signed [WIDTH-1:0]   y_res;
    logic signed [ANGLE_W-1:0] z_res;

    assign ready     = (state == ST_IDLE) || (state == ST_DONE);
    assign bus.ready = ready;
    assign bus.done  = done_r;
    assign bus.x_out = x_res;
    assign bus.y_out = y_res;
    assign bus.z_out = z_res;

`ifdef CORDIC_QUAD_EXT_EN
    localparam logic signed [ANGLE_W-1:0] HALF_PI = ANGLE_W'(longint'(1) <<< (ANGLE_W - 2));
`endif

    always_comb begin
        x_pre = x_r;
        y_pre = y_r;
        z_pre = z_r;
`ifdef CORDIC_QUAD_EXT_EN
        // Fold the operand into the right half-plane the iterations can converge over
        if (mode_r == MODE_ROT) begin
            if (z_r > HALF_PI) begin
                x_pre = -y_r;
                y_pre = x_r;
                z_pre = z_r - HALF_PI;
            end else if (z_r < -HALF_PI) begin
                x_pre = y_r;
                y_pre = -x_r;
                z_pre = z_r + HALF_PI;
            end
        end else if (x_r[IW-1]) begin
            if (!y_r[IW-1]) begin
                x_pre = y_r;
                y_pre = -x_r;
                z_pre = z_r + HALF_PI;
            end else begin
                x_pre = -y_r;
                y_pre = x_r;
                z_pre = z_r - HALF_PI;
            end
        end
`endif
    end

    // Zero counts as positive in both modes
    assign d_neg = (mode_r == MODE_VEC) ? ~y_r[IW-1] : z_r[ANGLE_W-1];

    cordic_stage #(
        .IW      (IW),
        .ANGLE_W (ANGLE_W)
    ) u_stage (
        .x      (x_r),
        .y      (y_r),
        .z      (z_r),
        .i      (iter),
        .d_neg  (d_neg),
        .x_next (x_nx),
        .y_next (y_nx),
        .z_next (z_nx)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= ST_IDLE;
            iter   <= '0;
            mode_r <= MODE_ROT;
            x_r    <= '0;
            y_r    <= '0;
            z_r    <= '0;
            done_r <= 1'b0;
            x_res  <= '0;
            y_res  <= '0;
            z_res  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        mode_r <= bus.mode;
                        x_r    <= {{2{bus.x_in[WIDTH-1]}}, bus.x_in};
                        y_r    <= {{2{bus.y_in[WIDTH-1]}}, bus.y_in};
                        z_r    <= bus.z_in;
                        done_r <= 1'b0;
                        state  <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    x_r   <= x_pre;
                    y_r   <= y_pre;
                    z_r   <= z_pre;
                    iter  <= '0;
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    x_r <= x_nx;
                    y_r <= y_nx;
                    z_r <= z_nx;
                    if (iter == LAST_ITER) begin
                        x_res  <= WIDTH'(sat_signed(longint'(x_nx), WIDTH));
                        y_res  <= WIDTH'(sat_signed(longint'(y_nx), WIDTH));
                        z_res  <= z_nx;
                        done_r <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        iter <= iter + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/cordic_engine.md
# cordic_engine

Parametrised iterative CORDIC core computing rotation (sin/cos, vector rotate) and vectoring (magnitude/atan2) in fixed point, one micro-rotation per clock. It is the reusable datapath under the chip-level CORDIC wrapper, which maps its 12-bit pin bus onto `start`/`mode`/operands and muxes results back out. Unlike the previous single-mode angle-in design, it generalises data width, angle width and iteration count, and adds vectoring, a start/done handshake and optional full-circle quadrant extension.

## Interface
- `WIDTH`, 12: x/y operand width, signed Q2.(WIDTH-2); 1.0 = 2^(WIDTH-2).
- `ANGLE_W`, 12: z width, signed; full scale ±π = ±2^(ANGLE_W-1).
- `ITERS`, 10: micro-rotations, 1..16; elaboration error outside this range.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low.
- `start`  in  1  request; accepted only in a cycle with `ready`=1.
- `mode`  in  1  0 = rotation (drive z to 0), 1 = vectoring (drive y to 0); sampled with `start`.
- `x_in`, `y_in`  in  WIDTH  operands, sampled with `start`.
- `z_in`  in  ANGLE_W  angle operand, sampled with `start`.
- `ready`  out  1  idle, may accept `start`.
- `done`  out  1  results valid; high from completion until next accepted `start` or reset.
- `x_out`, `y_out`  out  WIDTH  results, saturated.
- `z_out`  out  ANGLE_W  result angle, modular (wraps).

## Operation
- FSM: IDLE -> PRE -> ITER -> DONE -> (start) PRE. IDLE/DONE both assert `ready`.
- Accept: `start`&&`ready` latches operands and mode, clears `done`, enters PRE.
- PRE (1 cycle): quadrant pre-rotation (see Configuration); otherwise pass-through.
- ITER: counter i = 0..ITERS-1. d = sign(z) (rotation) or -sign(y) (vectoring), zero treated as positive. x' = x - d·(y>>>i), y' = y + d·(x>>>i), z' = z - d·atan(2^-i).
- Internal x/y carried at WIDTH+2 bits (2 guard bits); shifts arithmetic, truncating.
- Exit ITER after i = ITERS-1 -> DONE: x/y saturated to WIDTH signed range, z truncated to ANGLE_W; `done`=1.
- Outputs scaled by gain K ≈ 1.6468 (no compensation); caller pre-scales (x_in = round(0.60725·2^(WIDTH-2)) for unit sin/cos).
- `start` while busy (PRE/ITER): ignored, no effect.
- `mode`/operand changes after acceptance: ignored.

## Timing
- Reset (`reset`=0 at edge): state IDLE, `ready`=1, `done`=0, `x_out`=`y_out`=`z_out`=0. Applies mid-operation; computation discarded.
- Latency: start accepted at edge N -> `done`=1 after edge N+ITERS+1 (constant, mode- and macro-independent).
- Throughput: one operation per ITERS+2 cycles (back-to-back `start` in DONE cycle allowed).
- Outputs registered, stable while `done`=1.

## Configuration
- `CORDIC_QUAD_EXT_EN` defined: PRE rotates by ±π/2 when |z| > π/2 (rotation) or x < 0 (vectoring): x'=∓y, y'=±x, z'=z∓π/2 (rotation) / z'=z±π/2 (vectoring, sign chosen from y). Full ±π range valid.
- Undefined: PRE is pass-through. Valid domain |z_in| ≤ π/2 (rotation), x_in ≥ 0 (vectoring); outside it results unspecified. Latency unchanged.

## Structure
- Package `cordic_pkg`: atan table constant (16 entries, computed for ANGLE_W via function), FSM state enum, mode encoding constants, saturation function.
- One sub-module: `cordic_stage`, combinational single micro-rotation (x, y, z, i, d -> x', y', z'), instantiated once and reused each ITER cycle.

## Test plan
Defaults WIDTH=12, ANGLE_W=12, ITERS=10 (1.0 = 1024, π = 2048).
- Rotation x=622,y=0,z=512 (π/4) -> after 11 cycles `done`; x_out≈724, y_out≈724 (±3), z_out≈0 (±3).
- Rotation x=622,y=0,z=0 -> x_out≈1024, y_out≈0 (±3); `ready`=1 with `done`.
- Vectoring x=512,y=512,z=0 -> z_out≈512, x_out≈1192, y_out≈0 (±4).
- Macro defined: rotation x=622,y=0,z=1536 -> x_out≈-724, y_out≈724; vectoring x=-512,y=512 -> z_out≈1536, x_out≈1192.
- Overflow: vectoring x=1536,y=1536 -> x_out=2047 (saturated), z_out≈512.
- Handshake/reset: `start` pulsed in ITER ignored (single `done`, values of first op); `reset`=0 at ITER i=4 -> next cycle `ready`=1, `done`=0, all outputs 0.
